// File: rtl/alu_digit_serial.sv
// rtl/alu_digit_serial.sv - digit-serial ALU: WIDTH-bit op, DIGIT bits per cycle, low slice first
`timescale 1ns/1ps
module alu_digit_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             half,
    output logic             carry
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_hold;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic [2:0]       op_r;
    logic             chain;
    logic             half_w;
    logic [KW-1:0]    k;

    logic [DIGIT-1:0] a_k;
    logic [DIGIT-1:0] b_k;
    logic [DIGIT-1:0] slice;
    logic [DIGIT:0]   sum;
    logic [DIGIT:0]   diff;
    logic             cout;
    logic             is_sub;
    logic             half_next;
    logic [WIDTH-1:0] work_next;

    always_comb begin
        a_k    = a_sh[DIGIT-1:0];
        b_k    = b_sh[DIGIT-1:0];
        sum    = {1'b0, a_k} + {1'b0, b_k} + {{DIGIT{1'b0}}, chain};
        diff   = {1'b0, a_k} - {1'b0, b_k} - {{DIGIT{1'b0}}, chain};
        is_sub = (op_r == 3'd2) || (op_r == 3'd3) || (op_r == 3'd7);
        slice  = sum[DIGIT-1:0];
        cout   = sum[DIGIT];
        case (op_r)
            3'd2, 3'd3, 3'd7: begin slice = diff[DIGIT-1:0]; cout = diff[DIGIT]; end
            3'd4:             begin slice = a_k & b_k;       cout = 1'b0;        end
            3'd5:             begin slice = a_k ^ b_k;       cout = 1'b0;        end
            3'd6:             begin slice = a_k | b_k;       cout = 1'b0;        end
            default:          ;
        endcase
        // New slice enters at the top so the low slice ends at bit 0 after N shifts
        work_next = (work >> DIGIT) | (WIDTH'(slice) << (WIDTH - DIGIT));
        half_next = (k == '0) ? ((op_r == 3'd4) ? 1'b1 : cout) : half_w;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_hold <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            work   <= '0;
            op_r   <= '0;
            chain  <= 1'b0;
            half_w <= 1'b0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            half   <= 1'b0;
            carry  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_hold <= a;
                        a_sh   <= a;
                        b_sh   <= b;
                        op_r   <= op;
                        chain  <= (op == 3'd1 || op == 3'd3) ? cin : 1'b0;
                        k      <= '0;
                        work   <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    work   <= work_next;
                    chain  <= cout;
                    half_w <= half_next;
                    k      <= k + 1'b1;
                    if (k == K_LAST) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= (op_r == 3'd7) ? a_hold : work_next;
                        zero   <= (work_next == '0);
                        neg    <= is_sub;
                        half   <= half_next;
                        carry  <= cout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
